// File: rtl/proc_ctrl_pkg.sv
// Shared constants, FSM encoding and helpers for the reset/stall controller.
package proc_ctrl_pkg;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } ctrl_state_e;

  localparam int DEF_RESET_CYCLES   = 32;
  localparam int DEF_N_STALL        = 2;
  localparam int DEF_TIMEOUT_CYCLES = 255;
  localparam int DEF_CNT_W          = 32;

  // Ceiling log2, usable in parameter context.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/stall_channel.sv
// One stall requester: pending flag, watchdog timer and sticky timeout flag.
// Done has priority over a same-cycle request, giving a single-cycle stall.
module stall_channel
  import proc_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic req,
  input  logic done,
  output logic pending,
  output logic timeout
);

  localparam int TMR_W = clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] timer;

  // Pending/timer/timeout update; nothing can become pending outside RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      timer   <= '0;
      timeout <= 1'b0;
    end else if (!run) begin
      pending <= 1'b0;
      timer   <= '0;
    end else if (req && done) begin
      pending <= 1'b0;
    end else if (req) begin
      pending <= 1'b1;
      timer   <= '0;
    end else if (pending) begin
      if (done) begin
        pending <= 1'b0;
      end else if (timer == TMR_LAST) begin
        pending <= 1'b0;
        timeout <= 1'b1;
      end else begin
        timer <= timer + TMR_W'(1);
      end
    end
  end

endmodule

// File: rtl/proc_reset_stall_ctrl.sv
// Power-on reset sequencer and N-way stall merge into a processor clock-enable.
module proc_reset_stall_ctrl
  import proc_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES   = DEF_RESET_CYCLES,
  parameter int N_STALL        = DEF_N_STALL,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [N_STALL-1:0] stall_req_i,
  input  logic [N_STALL-1:0] stall_done_i,
  output logic               core_reset_n_o,
  output logic               proc_ce_o,
  output logic [N_STALL-1:0] stall_active_o,
  output logic [N_STALL-1:0] timeout_o,
  output logic [CNT_W-1:0]   stall_cycles_o,
  output logic               ready_o
);

  localparam int RST_W = clog2(RESET_CYCLES) + 1;
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);

  ctrl_state_e        state_q, state_d;
  logic [RST_W-1:0]   rst_cnt;
  logic [N_STALL-1:0] pending;
  logic               run;

  assign run            = (state_q == RUN);
  assign core_reset_n_o = run;
  assign ready_o        = run;
  assign stall_active_o = pending;
  // Request path is combinational so a stall bites in the cycle it is raised.
  assign proc_ce_o      = run & ~(|stall_req_i | |pending);

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= HOLD;
    else         state_q <= state_d;
  end

  // Leave HOLD once the hold counter reaches its last value.
  always_comb begin
    state_d = state_q;
    if (state_q == HOLD && rst_cnt == RST_LAST) state_d = RUN;
  end

  // Hold counter runs only in HOLD; it restarts from zero on every reset.
  always_ff @(posedge clk_i) begin
    if (reset_i)              rst_cnt <= '0;
    else if (state_q == HOLD) rst_cnt <= rst_cnt + RST_W'(1);
  end

  // Saturating count of RUN cycles in which the core was held.
  always_ff @(posedge clk_i) begin
    if (reset_i)
      stall_cycles_o <= '0;
    else if (run && !proc_ce_o && stall_cycles_o != '1)
      stall_cycles_o <= stall_cycles_o + CNT_W'(1);
  end

  for (genvar k = 0; k < N_STALL; k++) begin : g_ch
    stall_channel #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_ch (
      .clk     (clk_i),
      .rst     (reset_i),
      .run     (run),
      .req     (stall_req_i[k]),
      .done    (stall_done_i[k]),
      .pending (pending[k]),
      .timeout (timeout_o[k])
    );
  end

endmodule

// File: tb/tb_proc_reset_stall_ctrl.sv
// Scoreboard bench for proc_reset_stall_ctrl: expectations are queued as each
// cycle's stimulus is applied and compared mid-cycle against the outputs.
module tb_proc_reset_stall_ctrl;

  localparam int RC = 4;
  localparam int NS = 2;
  localparam int TO = 5;
  localparam int CW = 4;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic [NS-1:0] stall_req_i = '0;
  logic [NS-1:0] stall_done_i = '0;
  logic          core_reset_n_o;
  logic          proc_ce_o;
  logic [NS-1:0] stall_active_o;
  logic [NS-1:0] timeout_o;
  logic [CW-1:0] stall_cycles_o;
  logic          ready_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          rstn;
    logic          ce;
    logic [NS-1:0] act;
    logic [NS-1:0] to;
  } exp_t;

  exp_t sb[$];

  proc_reset_stall_ctrl #(
    .RESET_CYCLES(RC), .N_STALL(NS), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .stall_req_i(stall_req_i),
    .stall_done_i(stall_done_i), .core_reset_n_o(core_reset_n_o),
    .proc_ce_o(proc_ce_o), .stall_active_o(stall_active_o),
    .timeout_o(timeout_o), .stall_cycles_o(stall_cycles_o), .ready_o(ready_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Apply one cycle of stimulus just after the rising edge.
  task automatic drive(input logic rst, input logic [NS-1:0] r, input logic [NS-1:0] d);
    @(posedge clk_i);
    #1;
    reset_i = rst; stall_req_i = r; stall_done_i = d;
  endtask

  // Reset and wait until RUN has just been entered; inputs idle.
  task automatic do_reset();
    repeat (2) drive(1'b1, '0, '0);
    repeat (1 + RC) drive(1'b0, '0, '0);
  endtask

  task automatic test_reset();
    exp_t e;
    repeat (3) drive(1'b1, '0, '0);
    @(negedge clk_i);
    checks++;
    if ({core_reset_n_o, proc_ce_o, ready_o, stall_active_o, timeout_o, stall_cycles_o} !== '0) begin
      errors++;
      $display("FAIL reset_values: rstn=%b ce=%b rdy=%b act=%b to=%b cyc=%0d, all must be 0",
               core_reset_n_o, proc_ce_o, ready_o, stall_active_o, timeout_o, stall_cycles_o);
    end
    drive(1'b0, '0, '0);
    for (int k = 1; k <= 6; k++) begin
      // A request during HOLD must be dropped.
      drive(1'b0, (k == 2) ? 2'b01 : 2'b00, '0);
      sb.push_back('{rstn: (k >= RC), ce: (k >= RC), act: '0, to: '0});
      @(negedge clk_i);
      e = sb.pop_front();
      checks++;
      if ({core_reset_n_o, ready_o, proc_ce_o, stall_active_o, timeout_o} !== {e.rstn, e.rstn, e.ce, e.act, e.to}) begin
        errors++;
        $display("FAIL release edge=%0d: rstn=%b rdy=%b ce=%b act=%b to=%b, want rstn=%b rdy=%b ce=%b act=%b to=%b",
                 k, core_reset_n_o, ready_o, proc_ce_o, stall_active_o, timeout_o,
                 e.rstn, e.rstn, e.ce, e.act, e.to);
      end
    end
  endtask

  task automatic test_single_cycle();
    exp_t e;
    do_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, (c == 0) ? 2'b01 : 2'b00, (c == 0) ? 2'b01 : 2'b00);
      sb.push_back('{rstn: 1'b1, ce: (c != 0), act: '0, to: '0});
      @(negedge clk_i);
      e = sb.pop_front();
      checks++;
      if ({core_reset_n_o, proc_ce_o, stall_active_o, timeout_o} !== {e.rstn, e.ce, e.act, e.to}) begin
        errors++;
        $display("FAIL single c=%0d: rstn=%b ce=%b act=%b to=%b, want %b %b %b %b",
                 c, core_reset_n_o, proc_ce_o, stall_active_o, timeout_o, e.rstn, e.ce, e.act, e.to);
      end
    end
    checks++;
    if (stall_cycles_o !== 4'd1) begin
      errors++;
      $display("FAIL single_count: got %0d want 1", stall_cycles_o);
    end
  endtask

  task automatic test_overlap();
    exp_t e;
    do_reset();
    for (int c = 8; c <= 19; c++) begin
      drive(1'b0, {1'(c == 12), 1'(c == 10)}, {1'(c == 16), 1'(c == 13)});
      sb.push_back('{rstn: 1'b1, ce: !(c >= 10 && c <= 16),
                     act: {1'(c >= 13 && c <= 16), 1'(c >= 11 && c <= 13)}, to: '0});
      @(negedge clk_i);
      e = sb.pop_front();
      checks++;
      if ({core_reset_n_o, proc_ce_o, stall_active_o, timeout_o} !== {e.rstn, e.ce, e.act, e.to}) begin
        errors++;
        $display("FAIL overlap c=%0d: rstn=%b ce=%b act=%b to=%b, want %b %b %b %b",
                 c, core_reset_n_o, proc_ce_o, stall_active_o, timeout_o, e.rstn, e.ce, e.act, e.to);
      end
    end
    checks++;
    if (stall_cycles_o !== 4'd7) begin
      errors++;
      $display("FAIL overlap_count: got %0d want 7", stall_cycles_o);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      drive(1'b0, (c == 0) ? 2'b10 : 2'b00, (c == 8) ? 2'b10 : 2'b00);
      sb.push_back('{rstn: 1'b1, ce: (c > 5), act: {1'(c >= 1 && c <= 5), 1'b0},
                     to: {1'(c >= 6), 1'b0}});
      @(negedge clk_i);
      e = sb.pop_front();
      checks++;
      if ({core_reset_n_o, proc_ce_o, stall_active_o, timeout_o} !== {e.rstn, e.ce, e.act, e.to}) begin
        errors++;
        $display("FAIL timeout c=%0d: rstn=%b ce=%b act=%b to=%b, want %b %b %b %b",
                 c, core_reset_n_o, proc_ce_o, stall_active_o, timeout_o, e.rstn, e.ce, e.act, e.to);
      end
    end
    checks++;
    if (stall_cycles_o !== 4'd6) begin
      errors++;
      $display("FAIL timeout_count: got %0d want 6", stall_cycles_o);
    end
  endtask

  task automatic test_reset_mid_stall();
    exp_t e;
    logic rst;
    logic [NS-1:0] r;
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      rst = (c == 2);
      r   = (c == 0 || c == 4) ? 2'b01 : 2'b00;
      drive(rst, r, '0);
      if (c <= 2)      sb.push_back('{rstn: 1'b1, ce: 1'b0, act: (c == 0) ? 2'b00 : 2'b01, to: '0});
      else if (c <= 6) sb.push_back('{rstn: 1'b0, ce: 1'b0, act: '0, to: '0});
      else             sb.push_back('{rstn: 1'b1, ce: 1'b1, act: '0, to: '0});
      @(negedge clk_i);
      e = sb.pop_front();
      checks++;
      if ({core_reset_n_o, ready_o, proc_ce_o, stall_active_o, timeout_o} !== {e.rstn, e.rstn, e.ce, e.act, e.to}) begin
        errors++;
        $display("FAIL midreset c=%0d: rstn=%b rdy=%b ce=%b act=%b to=%b, want %b %b %b %b %b",
                 c, core_reset_n_o, ready_o, proc_ce_o, stall_active_o, timeout_o,
                 e.rstn, e.rstn, e.ce, e.act, e.to);
      end
      if (c == 2 || c == 3) begin
        checks++;
        if (stall_cycles_o !== ((c == 2) ? 4'd2 : 4'd0)) begin
          errors++;
          $display("FAIL midreset_count c=%0d: got %0d want %0d", c, stall_cycles_o, (c == 2) ? 2 : 0);
        end
      end
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    do_reset();
    for (int c = 0; c <= 21; c++) begin
      drive(1'b0, (c <= 19) ? 2'b01 : 2'b00, (c == 20) ? 2'b01 : 2'b00);
      sb.push_back('{rstn: 1'b1, ce: (c >= 21), act: {1'b0, 1'(c >= 1 && c <= 20)}, to: '0});
      @(negedge clk_i);
      e = sb.pop_front();
      checks++;
      if ({proc_ce_o, stall_active_o, timeout_o} !== {e.ce, e.act, e.to}) begin
        errors++;
        $display("FAIL saturate c=%0d: ce=%b act=%b to=%b, want %b %b %b",
                 c, proc_ce_o, stall_active_o, timeout_o, e.ce, e.act, e.to);
      end
      if (c == 14 || c == 16 || c == 21) begin
        checks++;
        if (stall_cycles_o !== ((c == 14) ? 4'd14 : 4'd15)) begin
          errors++;
          $display("FAIL saturate_count c=%0d: got %0d want %0d", c, stall_cycles_o, (c == 14) ? 14 : 15);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_overlap();
    test_timeout();
    test_reset_mid_stall();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/proc_reset_stall_ctrl.md
# proc_reset_stall_ctrl

Parametrised power-on reset sequencer and processor stall controller for the CPU/memory top level. It holds the core in reset for a programmable number of cycles and then releases it. It merges N independent stall requesters (data memory, future peripherals) into a single processor clock-enable, replacing the single-source gated processor clock. Each stall channel has a completion handshake, a timeout watchdog and a sticky error flag. A saturating stall-cycle counter is provided for debug and performance.

## Interface
Parameters:
- RESET_CYCLES, 32: cycles the core reset is held after reset_i deasserts; legal range ≥1.
- N_STALL, 2: number of stall requester channels; legal range 1..8.
- TIMEOUT_CYCLES, 255: maximum cycles a channel may stall before forced release; legal range ≥1.
- CNT_W, 32: width of the stall-cycle counter.

Ports:
- clk_i  in  1  system clock. The only clock; all logic is on the rising edge.
- reset_i  in  1  synchronous, active-high reset. This is fixed.
- stall_req_i  in  N_STALL  per-channel stall request. One-cycle pulse or level.
- stall_done_i  in  N_STALL  per-channel completion strobe.
- core_reset_n_o  out  1  active-low reset to the CPU, registered.
- proc_ce_o  out  1  processor clock-enable. 1 = CPU advances this cycle.
- stall_active_o  out  N_STALL  per-channel pending flag, registered.
- timeout_o  out  N_STALL  sticky per-channel timeout flag.
- stall_cycles_o  out  CNT_W  saturating count of stalled RUN cycles.
- ready_o  out  1  high while in RUN.

## Operation
- State machine: HOLD → RUN. There are no other states. reset_i in any state returns to HOLD on the next edge.
- **HOLD**
  - A counter (width clog2(RESET_CYCLES)+1) increments on each edge where reset_i=0.
  - When the counter equals RESET_CYCLES-1, the FSM moves to RUN.
  - In HOLD: core_reset_n_o=0, proc_ce_o=0, ready_o=0, and no channel may become pending.
- **RUN**
  - core_reset_n_o=1 and ready_o=1.
  - proc_ce_o = ~(|stall_req_i | |pending). The request path is combinational, so a stall takes effect in the same cycle the request is raised.
- **Stall channel k, RUN only**
  - Done priority: if stall_req_i[k] and stall_done_i[k] are both 1 at an edge, pending[k] is not set. This is a single-cycle stall.
  - Otherwise, stall_req_i[k]=1 sets pending[k] and clears timer[k].
  - While pending[k]=1, stall_done_i[k]=1 clears pending[k].
  - While pending[k]=1 and done is low, timer[k] increments.
  - When timer[k]==TIMEOUT_CYCLES-1 with no done, pending[k] clears and timeout_o[k] sets.
  - Re-request while pending: the timer restarts and the channel stays pending.
  - stall_done_i while not pending: ignored.
- stall_active_o = pending.
- timeout_o bits clear only on reset_i.
- stall_cycles_o increments on each RUN edge with proc_ce_o=0. It saturates at all-ones and clears on reset_i.
- Channels are independent. proc_ce_o stays 0 until every channel is idle and no request is asserted.

## Timing
- Reset values (edge with reset_i=1): core_reset_n_o=0, proc_ce_o=0, ready_o=0, stall_active_o=0, timeout_o=0, stall_cycles_o=0.
- Release: the first edge with reset_i=0 is edge 1. The FSM enters RUN at edge RESET_CYCLES. core_reset_n_o and ready_o are 1 from that edge onward.
- proc_ce_o has zero latency from stall_req_i. It drops back to 1 in the cycle after the edge that sampled the final stall_done_i.
- Timeout: pending is released at the TIMEOUT_CYCLES-th edge after the request edge. timeout_o[k] is visible from that edge.
- Reset mid-stall: all pending, timer and flag state clears at that edge. Sequencing restarts from HOLD with the full RESET_CYCLES count.
- Requests during HOLD are dropped. proc_ce_o stays 0 in HOLD.

## Structure
- Package proc_ctrl_pkg holds:
  - the state encoding (HOLD=1'b0, RUN=1'b1)
  - default parameter constants
  - a clog2 function
- Sub-module stall_channel is instantiated N_STALL times via generate. It contains the pending flop, timer, timeout flag and done-priority logic.
- The top contains the FSM, reset counter, proc_ce_o merge and stall-cycle counter.

## Test plan
- Reset release: RESET_CYCLES=4, reset_i high 3 cycles then low → core_reset_n_o=0 through edge 3, 1 from edge 4. ready_o is identical. proc_ce_o=0 throughout HOLD.
- Single-cycle stall: in RUN, pulse req[0] with done[0] in the same cycle → proc_ce_o=0 for exactly 1 cycle, stall_active_o=0, stall_cycles_o=1.
- Overlapping channels: req[0] at cycle 10 with done[0] at 13; req[1] at 12 with done[1] at 16 → proc_ce_o=0 for cycles 10–16, 1 at 17. stall_cycles_o=7.
- Timeout: TIMEOUT_CYCLES=5, req[1] with no done → stall_active_o[1] drops after 5 edges, timeout_o[1]=1 and stays 1. A subsequent done[1] has no effect.
- Reset mid-stall: req[0] pending, assert reset_i for 1 cycle → all outputs at reset values next edge. The full RESET_CYCLES hold repeats.
- Saturation: CNT_W=4, hold req[0] with done every 20 cycles for 20 cycles → stall_cycles_o sticks at 15.
